pipe_valid_param: RTL and testbench
===================================

Name: pipe_valid_param

Overview:
- Parametrised successor to the fixed-size per-signal pipeline-register modules in the vector core.
- Carries a WIDTH-bit field down DEPTH stages, with a valid bit per stage, per-stage enable and squash, and optional bubble collapse.
- Exposes every stage tap plus an occupancy count, for hazard detection in the vector pipeline control.

Parameters:
- WIDTH, 32: data bits per stage (>=1).
- DEPTH, 4: number of register stages (>=1).
- COLLAPSE, 0: 1 = an empty stage fills from its upstream stage even when its enable is low (bubble squeeze); 0 = plain enable-driven shifting.
- CNTW, 3: occupancy counter width; must satisfy 2^CNTW > DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- d  input  WIDTH  stage-0 source data.
- d_valid  input  1  stage-0 source valid.
- en  input  DEPTH  en[i] = stage i loads from its source this cycle.
- squash  input  DEPTH  squash[i] = stage i clears this cycle.
- q  output  WIDTH*(DEPTH+1)  taps. q[WIDTH-1:0] = d (combinational). Slice k (1..DEPTH) = stage k-1 register.
- q_valid  output  DEPTH+1  valid taps. q_valid[0] = d_valid. Bit k = stage k-1 valid.
- occupancy  output  CNTW  registered count of valid stages, 0..DEPTH.

Behaviour:
- Reset: resetn low clears, asynchronously, all stage data to 0, all stage valids to 0 and occupancy to 0. Assertion mid-operation clears immediately; no partial state survives. First load is possible on the first rising edge after deassertion.
- Source of stage i: stage 0 uses (d, d_valid); stage i>0 uses stage i-1 data and valid.
- Load condition: load[i] = en[i] | (COLLAPSE & ~v[i] & src_valid[i]).
- Per-stage priority at each edge:
  1. squash[i] -> data 0, valid 0, regardless of en or collapse.
  2. else if load[i] -> data and valid copied from the source; an invalid source copies valid 0 and its data.
  3. else if drained[i] -> valid 0, data held.
  4. else hold.
- drained[i] (COLLAPSE=1 only): stage i+1 loads via collapse with en[i+1]=0, and stage i does not itself load or squash. This prevents duplicating an entry. The last stage never drains.
- With COLLAPSE=0 a stage's content is never removed by downstream movement; en-driven copies may duplicate entries, matching legacy pipe semantics.
- Latency: data presented with en[0]=1 appears on tap 1 one cycle later. With all en high it reaches tap DEPTH after DEPTH cycles.
- Squash upstream of a moving entry does not affect the entry that has already moved. The squash applies to the stage's next-state content only.
- occupancy: next value = popcount of next-state stage valids, registered in the same edge as the stages. It never exceeds DEPTH.
- All stages update simultaneously from current-cycle values; there is no intra-cycle ripple.
- X-free: unused en/squash bits for stages that hold take no effect.

Test Plan:
- Reset mid-stream: WIDTH=32, DEPTH=4, all en=1; feed 0xA0..0xA3 with d_valid=1; drop resetn asynchronously between edges -> q_valid[4:1]=0, occupancy=0 immediately, all stage data 0.
- Straight flow: all en=1, d=0x11 valid for 1 cycle then d_valid=0 -> 0x11 seen on taps 1,2,3,4 on edges 1..4, valid only in the moving slot; occupancy 1,1,1,1 then 0.
- Squash priority: stage 2 holds 0x55 valid; assert en[2]=1 and squash[2]=1 together -> stage 2 = 0, valid 0; stage 3 receives the stage-2 old value if en[3]=1.
- Stall/duplicate (COLLAPSE=0): en=4'b0001 with stage 0 = 0x7 valid, d=0x8 valid -> stage 0 = 0x8, stage 1 unchanged, occupancy unchanged. Then en=4'b0010 -> stage 1 = 0x8, stage 0 still 0x8 valid, occupancy +1.
- Bubble collapse (COLLAPSE=1): stages 0..3 valid = 1,0,0,1 holding 0x3 in stage 0, en=0 -> edge 1: stage 1 = 0x3 valid, stage 0 drained invalid. Edge 2: stage 2 valid. Stage 3 is not overwritten. occupancy stays 2 throughout.
- Parameter sweep: DEPTH=1, WIDTH=1 and DEPTH=8, WIDTH=10 (CNTW=4) -> fill all stages with en all high and d_valid=1 -> occupancy reaches DEPTH exactly and saturates there with continued input.

Source files
------------

// File: rtl/pipe_valid_param_if.sv
// rtl/pipe_valid_param_if.sv - stream and tap bundle for the parametrised valid pipeline
//
// Purpose: groups the source stream, per-stage controls and the tap/occupancy
// outputs of pipe_valid_param so one bundle connects the pipe to its control.
// Signals:
//   d, d_valid   stage-0 source data and valid
//   en, squash   per-stage load enable and clear
//   q, q_valid   taps: slice 0 = source, slice k = stage k-1 register
//   occupancy    registered count of valid stages
// Modports: master drives source/controls, slave is the pipeline itself.
interface pipe_valid_param_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNTW  = 3
);
  logic [WIDTH-1:0]           d;
  logic                       d_valid;
  logic [DEPTH-1:0]           en;
  logic [DEPTH-1:0]           squash;
  logic [WIDTH*(DEPTH+1)-1:0] q;
  logic [DEPTH:0]             q_valid;
  logic [CNTW-1:0]            occupancy;

  modport master (
    output d, d_valid, en, squash,
    input  q, q_valid, occupancy
  );

  modport slave (
    input  d, d_valid, en, squash,
    output q, q_valid, occupancy
  );
endinterface

// File: rtl/pipe_valid_param.sv
// rtl/pipe_valid_param.sv - WIDTH x DEPTH valid pipeline with enable, squash and bubble collapse
//
// Purpose: carries a WIDTH-bit field down DEPTH register stages, each with its
// own valid bit, enable and squash. With COLLAPSE=1 an empty stage pulls from a
// valid upstream stage even without its enable, squeezing bubbles out.
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset (clears data, valids, occupancy)
//   bus     pipe_valid_param_if slave: d/d_valid/en/squash in,
//           q/q_valid taps and occupancy out
module pipe_valid_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int COLLAPSE = 0,
  parameter int CNTW     = 3
) (
  input logic                clk,
  input logic                resetn,
  pipe_valid_param_if.slave  bus
);

  localparam logic COL = (COLLAPSE != 0);

  logic [WIDTH-1:0] r     [DEPTH];
  logic [WIDTH-1:0] nr    [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] nv;
  logic [DEPTH-1:0] src_v;
  logic [DEPTH-1:0] cload;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] drained;
  logic [CNTW-1:0]  occ;
  logic [CNTW-1:0]  nocc;

  // Stage sources: stage 0 from the input port, others from the stage above.
  always_comb begin
    src_d[0] = bus.d;
    src_v[0] = bus.d_valid;
    for (int i = 1; i < DEPTH; i++) begin
      src_d[i] = r[i-1];
      src_v[i] = v[i-1];
    end
  end

  // cload: empty stage squeezing in a valid upstream entry without its enable.
  // drained: the upstream stage gave its entry away by collapse and did not
  // reload itself, so its valid must drop or the entry would exist twice.
  always_comb begin
    cload   = {DEPTH{COL}} & ~v & src_v;
    load    = bus.en | cload;
    drained = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      drained[i] = cload[i+1] & ~bus.en[i+1] & ~load[i] & ~bus.squash[i];
    end
  end

  // Next-state per stage: squash > load > drained > hold.
  always_comb begin
    nocc = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.squash[i]) begin
        nr[i] = '0;
        nv[i] = 1'b0;
      end else if (load[i]) begin
        nr[i] = src_d[i];
        nv[i] = src_v[i];
      end else if (drained[i]) begin
        nr[i] = r[i];
        nv[i] = 1'b0;
      end else begin
        nr[i] = r[i];
        nv[i] = v[i];
      end
      nocc = nocc + CNTW'(nv[i]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r[i] <= '0;
      end
      v   <= '0;
      occ <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r[i] <= nr[i];
      end
      v   <= nv;
      occ <= nocc;
    end
  end

  always_comb begin
    bus.q              = '0;
    bus.q[WIDTH-1:0]   = bus.d;
    for (int k = 1; k <= DEPTH; k++) begin
      bus.q[k*WIDTH +: WIDTH] = r[k-1];
    end
  end

  assign bus.q_valid   = {v, bus.d_valid};
  assign bus.occupancy = occ;

endmodule

// File: tb/tb_pipe_valid_param.sv
// tb/tb_pipe_valid_param.sv - directed vector bench for pipe_valid_param
module tb_pipe_valid_param;

  logic clk;
  logic resetn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_valid_param_if #(.WIDTH(32), .DEPTH(4), .CNTW(3)) ia ();
  pipe_valid_param_if #(.WIDTH(32), .DEPTH(4), .CNTW(3)) ib ();
  pipe_valid_param_if #(.WIDTH(1),  .DEPTH(1), .CNTW(3)) ic ();
  pipe_valid_param_if #(.WIDTH(10), .DEPTH(8), .CNTW(4)) id ();

  pipe_valid_param #(.WIDTH(32), .DEPTH(4), .COLLAPSE(0), .CNTW(3)) dut_a (.clk(clk), .resetn(resetn), .bus(ia));
  pipe_valid_param #(.WIDTH(32), .DEPTH(4), .COLLAPSE(1), .CNTW(3)) dut_b (.clk(clk), .resetn(resetn), .bus(ib));
  pipe_valid_param #(.WIDTH(1),  .DEPTH(1), .COLLAPSE(0), .CNTW(3)) dut_c (.clk(clk), .resetn(resetn), .bus(ic));
  pipe_valid_param #(.WIDTH(10), .DEPTH(8), .COLLAPSE(0), .CNTW(4)) dut_d (.clk(clk), .resetn(resetn), .bus(id));

  typedef struct {
    logic             col;
    logic [31:0]      d;
    logic             dv;
    logic [3:0]       en;
    logic [3:0]       sq;
    logic [3:0]       ev;
    logic [3:0][31:0] ed;
    logic [2:0]       eo;
  } vec_t;

  localparam int NV = 25;
  vec_t tv [NV];

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic col, input logic [31:0] d, input logic dv,
                              input logic [3:0] en, input logic [3:0] sq, input logic [3:0] ev,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3,
                              input logic [2:0] eo);
    vec_t t;
    t.col = col; t.d = d; t.dv = dv; t.en = en; t.sq = sq; t.ev = ev;
    t.ed[0] = e0; t.ed[1] = e1; t.ed[2] = e2; t.ed[3] = e3; t.eo = eo;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ia.d = '0; ia.d_valid = 1'b0; ia.en = '0; ia.squash = '0;
    ib.d = '0; ib.d_valid = 1'b0; ib.en = '0; ib.squash = '0;
    ic.d = '0; ic.d_valid = 1'b0; ic.en = '0; ic.squash = '0;
    id.d = '0; id.d_valid = 1'b0; id.en = '0; id.squash = '0;
  endtask

  initial begin
    logic [159:0] qq;
    logic [4:0]   qv;
    logic [2:0]   oc;

    // COLLAPSE=0: straight flow, squash priority, stall/duplicate
    tv[0]  = mk(0, 32'h11, 1, 4'hF, 4'h0, 4'b0001, 32'h11, 0, 0, 0, 1);
    tv[1]  = mk(0, 32'h00, 0, 4'hF, 4'h0, 4'b0010, 0, 32'h11, 0, 0, 1);
    tv[2]  = mk(0, 32'h00, 0, 4'hF, 4'h0, 4'b0100, 0, 0, 32'h11, 0, 1);
    tv[3]  = mk(0, 32'h00, 0, 4'hF, 4'h0, 4'b1000, 0, 0, 0, 32'h11, 1);
    tv[4]  = mk(0, 32'h00, 0, 4'hF, 4'h0, 4'b0000, 0, 0, 0, 0, 0);
    tv[5]  = mk(0, 32'h55, 1, 4'hF, 4'h0, 4'b0001, 32'h55, 0, 0, 0, 1);
    tv[6]  = mk(0, 32'h00, 0, 4'hF, 4'h0, 4'b0010, 0, 32'h55, 0, 0, 1);
    tv[7]  = mk(0, 32'h00, 0, 4'hF, 4'h0, 4'b0100, 0, 0, 32'h55, 0, 1);
    tv[8]  = mk(0, 32'h00, 0, 4'hF, 4'b0100, 4'b1000, 0, 0, 0, 32'h55, 1);
    tv[9]  = mk(0, 32'h07, 1, 4'b0001, 4'h0, 4'b1001, 32'h07, 0, 0, 32'h55, 2);
    tv[10] = mk(0, 32'h08, 1, 4'b0001, 4'h0, 4'b1001, 32'h08, 0, 0, 32'h55, 2);
    tv[11] = mk(0, 32'h09, 1, 4'b0010, 4'h0, 4'b1011, 32'h08, 32'h08, 0, 32'h55, 3);
    tv[12] = mk(0, 32'h00, 0, 4'h0, 4'b1000, 4'b0011, 32'h08, 32'h08, 0, 0, 2);
    tv[13] = mk(0, 32'h00, 0, 4'hF, 4'hF, 4'b0000, 0, 0, 0, 0, 0);
    // COLLAPSE=1: position entries, then squeeze bubbles
    tv[14] = mk(1, 32'h0C, 1, 4'b0001, 4'h0, 4'b0001, 32'h0C, 0, 0, 0, 1);
    tv[15] = mk(1, 32'h00, 0, 4'hF, 4'h0, 4'b0010, 0, 32'h0C, 0, 0, 1);
    tv[16] = mk(1, 32'h00, 0, 4'hF, 4'h0, 4'b0100, 0, 0, 32'h0C, 0, 1);
    tv[17] = mk(1, 32'h00, 0, 4'hF, 4'h0, 4'b1000, 0, 0, 0, 32'h0C, 1);
    tv[18] = mk(1, 32'h03, 1, 4'b0001, 4'h0, 4'b1001, 32'h03, 0, 0, 32'h0C, 2);
    tv[19] = mk(1, 32'h00, 0, 4'h0, 4'h0, 4'b1010, 32'h03, 32'h03, 0, 32'h0C, 2);
    tv[20] = mk(1, 32'h00, 0, 4'h0, 4'h0, 4'b1100, 32'h03, 32'h03, 32'h03, 32'h0C, 2);
    tv[21] = mk(1, 32'h00, 0, 4'h0, 4'h0, 4'b1100, 32'h03, 32'h03, 32'h03, 32'h0C, 2);
    tv[22] = mk(1, 32'h44, 1, 4'h0, 4'h0, 4'b1101, 32'h44, 32'h03, 32'h03, 32'h0C, 3);
    tv[23] = mk(1, 32'h00, 0, 4'h0, 4'h0, 4'b1110, 32'h44, 32'h44, 32'h03, 32'h0C, 3);
    tv[24] = mk(1, 32'h66, 1, 4'h0, 4'b0001, 4'b1110, 32'h00, 32'h44, 32'h03, 32'h0C, 3);

    resetn = 1'b0;
    idle_all();
    tick();
    tick();
    chk("rst_a_valid", 160'(ia.q_valid), 160'h0);
    chk("rst_a_occ",   160'(ia.occupancy), 160'h0);
    chk("rst_a_data",  ia.q, 160'h0);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      idle_all();
      if (tv[i].col) begin
        ib.d = tv[i].d; ib.d_valid = tv[i].dv; ib.en = tv[i].en; ib.squash = tv[i].sq;
      end else begin
        ia.d = tv[i].d; ia.d_valid = tv[i].dv; ia.en = tv[i].en; ia.squash = tv[i].sq;
      end
      tick();
      if (tv[i].col) begin
        qq = ib.q; qv = ib.q_valid; oc = ib.occupancy;
      end else begin
        qq = ia.q; qv = ia.q_valid; oc = ia.occupancy;
      end
      chk($sformatf("v%0d_valid", i), 160'(qv[4:1]), 160'(tv[i].ev));
      chk($sformatf("v%0d_occ", i),   160'(oc),      160'(tv[i].eo));
      chk($sformatf("v%0d_tap0", i),  160'({qv[0], qq[31:0]}), 160'({tv[i].dv, tv[i].d}));
      for (int s = 0; s < 4; s++) begin
        chk($sformatf("v%0d_s%0d", i, s), 160'(qq[32*(s+1) +: 32]), 160'(tv[i].ed[s]));
      end
    end

    // Reset mid-stream on a full pipe
    idle_all();
    ia.en = 4'hF; ia.d_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ia.d = 32'hA0 + 32'(k);
      tick();
    end
    chk("mid_full_occ", 160'(ia.occupancy), 160'd4);
    chk("mid_full_s3",  160'(ia.q[159:128]), 160'hA0);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", 160'(ia.q_valid[4:1]), 160'h0);
    chk("mid_rst_occ",   160'(ia.occupancy), 160'h0);
    chk("mid_rst_data",  160'(ia.q[159:32]), 160'h0);
    chk("mid_rst_b_occ", 160'(ib.occupancy), 160'h0);
    tick();
    resetn = 1'b1;
    ia.d = 32'h5A; ia.en = 4'b0001; ia.d_valid = 1'b1;
    tick();
    chk("post_rst_s0",  160'(ia.q[63:32]), 160'h5A);
    chk("post_rst_occ", 160'(ia.occupancy), 160'd1);
    idle_all();

    // DEPTH=1 WIDTH=1 saturation
    ic.en = 1'b1; ic.d_valid = 1'b1; ic.d = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("c_occ%0d", k), 160'(ic.occupancy), 160'd1);
      chk($sformatf("c_qv%0d", k),  160'(ic.q_valid), 160'b11);
    end
    idle_all();

    // DEPTH=8 WIDTH=10 fill and saturation
    id.en = 8'hFF; id.d_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      id.d = 10'h100 + 10'(k);
      tick();
      chk($sformatf("d_occ%0d", k), 160'(id.occupancy), 160'((k + 1 > 8) ? 8 : k + 1));
    end
    chk("d_qv_full", 160'(id.q_valid), 160'h1FF);
    chk("d_s7",      160'(id.q[89:80]), 160'h104);
    idle_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
